// File: rtl/tvs_monitor_pkg.sv
// Shared types and constants for the TVS monitor.
// Register offsets, channel encodings, reset values, stats helper.
package tvs_monitor_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    CH_1V0  = 2'd0,
    CH_1V8  = 2'd1,
    CH_2V5  = 2'd2,
    CH_TEMP = 2'd3
  } tvs_ch_e;

  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_STATUS = 4'd1;
  localparam logic [3:0] REG_LAST0  = 4'd2;
  localparam logic [3:0] REG_LAST3  = 4'd5;
  localparam logic [3:0] REG_MIN0   = 4'd6;
  localparam logic [3:0] REG_MIN3   = 4'd9;
  localparam logic [3:0] REG_MAX0   = 4'd10;
  localparam logic [3:0] REG_MAX3   = 4'd13;
  localparam logic [3:0] REG_CNT    = 4'd14;

  localparam logic [15:0] MIN_RST = 16'hFFFF;
  localparam logic [15:0] MAX_RST = 16'h0000;
  localparam logic [3:0]  EN_RST  = 4'hF;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_PULSE = 1'b1
  } clr_state_e;

  typedef struct packed {
    logic [15:0] last;
    logic [15:0] min;
    logic [15:0] max;
  } ch_stats_t;

  localparam ch_stats_t STATS_RST_VAL = '{
    last: 16'h0000,
    min:  MIN_RST,
    max:  MAX_RST
  };

  function automatic ch_stats_t stats_update(
    input ch_stats_t   s,
    input logic [15:0] v
  );
    ch_stats_t r;
    r.last = v;
    r.min  = (v < s.min) ? v : s.min;
    r.max  = (v > s.max) ? v : s.max;
    return r;
  endfunction

endpackage

// File: rtl/tvs_monitor_sync_edge.sv
// Multi-stage synchronizer with level and rising-edge outputs.
// Ports: clk, rst_n, d (async in), level (synced), rise (1-cycle).
module tvs_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain   <= '0;
      level_d <= 1'b0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      level_d <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~level_d;

endmodule

// File: rtl/tvs_monitor.sv
// APB-mapped consumer of the TVS hard block: per-channel stats,
// sample counter, sticky alarms, enables and alarm-clear pulses.
module tvs_monitor
  import tvs_monitor_pkg::*;
#(
  parameter int SYNC_STAGES      = 2,
  parameter int CLR_PULSE_CYCLES = 16
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [5:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic [15:0] TVS_VALUE,
  input  logic [1:0]  TVS_CHANNEL,
  input  logic        TVS_VALID,
  input  logic        TVS_ACTIVE,
  input  logic        TVS_TEMP_HIGH,
  input  logic        TVS_TEMP_LOW,
  output logic [3:0]  TVS_EN,
  output logic        TVS_TEMP_HIGH_CLEAR,
  output logic        TVS_TEMP_LOW_CLEAR
);

  localparam int CW =
    (CLR_PULSE_CYCLES > 1) ? $clog2(CLR_PULSE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD =
    CW'(CLR_PULSE_CYCLES - 1);

  logic valid_lvl, valid_rise;
  logic high_lvl, high_rise;
  logic low_lvl, low_rise;
  logic active_lvl, active_rise;

  tvs_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_valid (
    .clk   (PCLK),
    .rst_n (PRESETN),
    .d     (TVS_VALID),
    .level (valid_lvl),
    .rise  (valid_rise)
  );

  tvs_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_high (
    .clk   (PCLK),
    .rst_n (PRESETN),
    .d     (TVS_TEMP_HIGH),
    .level (high_lvl),
    .rise  (high_rise)
  );

  tvs_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_low (
    .clk   (PCLK),
    .rst_n (PRESETN),
    .d     (TVS_TEMP_LOW),
    .level (low_lvl),
    .rise  (low_rise)
  );

  tvs_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_active (
    .clk   (PCLK),
    .rst_n (PRESETN),
    .d     (TVS_ACTIVE),
    .level (active_lvl),
    .rise  (active_rise)
  );

  logic sig_unused;
  assign sig_unused = ^{PADDR[1:0], PWDATA[31:5],
                        valid_lvl, high_lvl, low_lvl,
                        active_rise};

  // APB decode
  logic [3:0] idx;
  logic       wr_en;
  logic       ctrl_wr;
  logic       status_wr;
  logic       stats_rst;
  logic [1:0] w1c;

  assign PREADY    = 1'b1;
  assign PSLVERR   = 1'b0;
  assign idx       = PADDR[5:2];
  assign wr_en     = PSEL & PENABLE & PWRITE;
  assign ctrl_wr   = wr_en && (idx == REG_CTRL);
  assign status_wr = wr_en && (idx == REG_STATUS);
  assign stats_rst = ctrl_wr & PWDATA[4];
  assign w1c[0]    = status_wr & PWDATA[1];
  assign w1c[1]    = status_wr & PWDATA[2];

  // Enables
  logic [3:0] en_q;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      en_q <= EN_RST;
    end else if (ctrl_wr) begin
      en_q <= PWDATA[3:0];
    end
  end

  assign TVS_EN = en_q;

  // Sticky alarms: a same-cycle set beats the W1C.
  logic high_q, low_q;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      high_q <= 1'b0;
      low_q  <= 1'b0;
    end else begin
      high_q <= high_rise | (high_q & ~w1c[0]);
      low_q  <= low_rise  | (low_q  & ~w1c[1]);
    end
  end

  // Stats and sample counter
  ch_stats_t   stats_q [NUM_CH];
  ch_stats_t   stats_d [NUM_CH];
  logic [31:0] cnt_q;

  // A capture coinciding with STATS_RST seeds that channel
  // from the reset value, so MIN=MAX=new sample.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_stats_t base;
      base = stats_rst ? STATS_RST_VAL : stats_q[i];
      stats_d[i] = base;
      if (valid_rise && (TVS_CHANNEL == 2'(i))) begin
        stats_d[i] = stats_update(base, TVS_VALUE);
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        stats_q[i] <= STATS_RST_VAL;
      end
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        stats_q[i] <= stats_d[i];
      end
      if (valid_rise) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  // Read mux, registered in the setup phase so PRDATA is
  // stable throughout the access phase.
  logic [31:0] rdata;
  logic [1:0]  ch_sel;

  // LAST/MIN/MAX blocks start at offsets 2, 6, 10: all are
  // 2 mod 4, so the channel is idx[1:0]-2 in every block.
  assign ch_sel = idx[1:0] - 2'd2;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (idx == REG_CTRL):
        rdata = {28'd0, en_q};
      (idx == REG_STATUS):
        rdata = {29'd0, low_q, high_q, active_lvl};
      (idx >= REG_LAST0 && idx <= REG_LAST3):
        rdata = {16'd0, stats_q[ch_sel].last};
      (idx >= REG_MIN0 && idx <= REG_MIN3):
        rdata = {16'd0, stats_q[ch_sel].min};
      (idx >= REG_MAX0 && idx <= REG_MAX3):
        rdata = {16'd0, stats_q[ch_sel].max};
      (idx == REG_CNT):
        rdata = cnt_q;
      default:
        rdata = '0;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      PRDATA <= '0;
    end else if (PSEL && !PENABLE && !PWRITE) begin
      PRDATA <= rdata;
    end
  end

  // Clear-pulse FSMs: [0]=TEMP_HIGH, [1]=TEMP_LOW
  logic [1:0] clr_out;

  for (genvar g = 0; g < 2; g++) begin : g_clr
    clr_state_e    st_q, st_d;
    logic [CW-1:0] cnt_q_l, cnt_d_l;
    logic          pulse;

    always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
        st_q    <= CLR_IDLE;
        cnt_q_l <= '0;
      end else begin
        st_q    <= st_d;
        cnt_q_l <= cnt_d_l;
      end
    end

    always_comb begin
      st_d    = st_q;
      cnt_d_l = cnt_q_l;
      unique case (st_q)
        CLR_IDLE: begin
          if (w1c[g]) begin
            st_d    = CLR_PULSE;
            cnt_d_l = CNT_LOAD;
          end
        end
        CLR_PULSE: begin
          if (w1c[g]) begin
            cnt_d_l = CNT_LOAD;
          end else if (cnt_q_l == '0) begin
            st_d = CLR_IDLE;
          end else begin
            cnt_d_l = cnt_q_l - 1'b1;
          end
        end
        default: st_d = CLR_IDLE;
      endcase
    end

    always_comb begin
      pulse = (st_q == CLR_PULSE);
    end

    assign clr_out[g] = pulse;
  end

  assign TVS_TEMP_HIGH_CLEAR = clr_out[0];
  assign TVS_TEMP_LOW_CLEAR  = clr_out[1];

endmodule

// File: tb/tb_tvs_monitor.sv
// Directed self-checking bench for tvs_monitor.
// Drives APB and TVS inputs on negedges, samples on negedges.
module tb_tvs_monitor;

  logic        PCLK = 1'b0;
  logic        PRESETN;
  logic        PSEL, PENABLE, PWRITE;
  logic [5:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [15:0] TVS_VALUE;
  logic [1:0]  TVS_CHANNEL;
  logic        TVS_VALID, TVS_ACTIVE;
  logic        TVS_TEMP_HIGH, TVS_TEMP_LOW;
  logic [3:0]  TVS_EN;
  logic        TVS_TEMP_HIGH_CLEAR, TVS_TEMP_LOW_CLEAR;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 PCLK = ~PCLK;

  tvs_monitor dut (
    .PCLK                (PCLK),
    .PRESETN             (PRESETN),
    .PSEL                (PSEL),
    .PENABLE             (PENABLE),
    .PWRITE              (PWRITE),
    .PADDR               (PADDR),
    .PWDATA              (PWDATA),
    .PRDATA              (PRDATA),
    .PREADY              (PREADY),
    .PSLVERR             (PSLVERR),
    .TVS_VALUE           (TVS_VALUE),
    .TVS_CHANNEL         (TVS_CHANNEL),
    .TVS_VALID           (TVS_VALID),
    .TVS_ACTIVE          (TVS_ACTIVE),
    .TVS_TEMP_HIGH       (TVS_TEMP_HIGH),
    .TVS_TEMP_LOW        (TVS_TEMP_LOW),
    .TVS_EN              (TVS_EN),
    .TVS_TEMP_HIGH_CLEAR (TVS_TEMP_HIGH_CLEAR),
    .TVS_TEMP_LOW_CLEAR  (TVS_TEMP_LOW_CLEAR)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, got, exp);
    end
  endtask

  task automatic apb_wr(input logic [3:0] r, input logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = {r, 2'b00}; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [3:0] r, output logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = {r, 2'b00};
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    d = PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic rd_chk(
    input string       tag,
    input logic [3:0]  r,
    input logic [31:0] exp
  );
    logic [31:0] d;
    apb_rd(r, d);
    check(tag, d, exp);
  endtask

  task automatic sample(input logic [1:0] ch, input logic [15:0] v);
    @(negedge PCLK);
    TVS_CHANNEL = ch; TVS_VALUE = v; TVS_VALID = 1'b1;
    repeat (4) @(negedge PCLK);
    TVS_VALID = 1'b0;
    repeat (4) @(negedge PCLK);
  endtask

  // Counts negedges on which the chosen clear output is high.
  task automatic pulse_len(input logic sel_low, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if ((sel_low ? TVS_TEMP_LOW_CLEAR : TVS_TEMP_HIGH_CLEAR))
        n++;
      @(negedge PCLK);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp;
    int          n;

    PRESETN = 1'b0;
    PSEL = 0; PENABLE = 0; PWRITE = 0;
    PADDR = '0; PWDATA = '0;
    TVS_VALUE = '0; TVS_CHANNEL = '0;
    TVS_VALID = 0; TVS_ACTIVE = 0;
    TVS_TEMP_HIGH = 0; TVS_TEMP_LOW = 0;
    repeat (3) @(negedge PCLK);
    PRESETN = 1'b1;

    // 1: reset values
    check("rst_en", {28'd0, TVS_EN}, 32'hF);
    check("rst_hclr", {31'd0, TVS_TEMP_HIGH_CLEAR}, 32'd0);
    check("rst_lclr", {31'd0, TVS_TEMP_LOW_CLEAR}, 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    check("pready", {31'd0, PREADY}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      if (i == 0)               exp = 32'hF;
      else if (i >= 6 && i <= 9) exp = 32'hFFFF;
      else                      exp = 32'h0;
      rd_chk($sformatf("rst_reg%0d", i), 4'(i), exp);
    end

    TVS_ACTIVE = 1'b1;
    repeat (4) @(negedge PCLK);
    rd_chk("active", 4'd1, 32'h1);
    TVS_ACTIVE = 1'b0;
    repeat (4) @(negedge PCLK);

    // 2: ch3 samples
    sample(2'd3, 16'h1112);
    sample(2'd3, 16'h0F00);
    sample(2'd3, 16'h1300);
    rd_chk("last3", 4'd5, 32'h1300);
    rd_chk("min3", 4'd9, 32'h0F00);
    rd_chk("max3", 4'd13, 32'h1300);
    rd_chk("cnt3", 4'd14, 32'd3);
    rd_chk("last0", 4'd2, 32'h0);
    apb_wr(4'd5, 32'h1234);
    rd_chk("ro_last3", 4'd5, 32'h1300);
    apb_wr(4'd15, 32'hFFFF_FFFF);
    rd_chk("rsvd", 4'd15, 32'h0);

    // 3: TEMP_HIGH sticky and 16-cycle clear pulse
    TVS_TEMP_HIGH = 1'b1;
    repeat (5) @(negedge PCLK);
    rd_chk("high_sticky", 4'd1, 32'h2);
    TVS_TEMP_HIGH = 1'b0;
    repeat (3) @(negedge PCLK);
    rd_chk("high_held", 4'd1, 32'h2);
    check("hclr_idle", {31'd0, TVS_TEMP_HIGH_CLEAR}, 32'd0);
    apb_wr(4'd1, 32'h2);
    check("lclr_quiet", {31'd0, TVS_TEMP_LOW_CLEAR}, 32'd0);
    pulse_len(1'b0, n);
    check("hclr_len", 32'(n), 32'd16);
    rd_chk("high_w1c", 4'd1, 32'h0);

    // 4: W1C on the same edge as synced TEMP_LOW rise
    @(negedge PCLK);
    TVS_TEMP_LOW = 1'b1;
    apb_wr(4'd1, 32'h4);
    pulse_len(1'b1, n);
    check("lclr_len", 32'(n), 32'd16);
    rd_chk("low_set_wins", 4'd1, 32'h4);
    TVS_TEMP_LOW = 1'b0;
    apb_wr(4'd1, 32'h4);
    repeat (2) @(negedge PCLK);
    rd_chk("low_w1c", 4'd1, 32'h0);
    repeat (20) @(negedge PCLK);

    // 5: STATS_RST coincident with a ch0 capture
    sample(2'd0, 16'h0100);
    sample(2'd1, 16'h2000);
    rd_chk("min0_pre", 4'd6, 32'h0100);
    @(negedge PCLK);
    TVS_CHANNEL = 2'd0; TVS_VALUE = 16'h0800; TVS_VALID = 1'b1;
    apb_wr(4'd0, 32'h1F);
    repeat (3) @(negedge PCLK);
    TVS_VALID = 1'b0;
    repeat (4) @(negedge PCLK);
    rd_chk("srst_min0", 4'd6, 32'h0800);
    rd_chk("srst_max0", 4'd10, 32'h0800);
    rd_chk("srst_last0", 4'd2, 32'h0800);
    rd_chk("srst_min1", 4'd7, 32'hFFFF);
    rd_chk("srst_max1", 4'd11, 32'h0);
    rd_chk("srst_min3", 4'd9, 32'hFFFF);
    rd_chk("srst_max3", 4'd13, 32'h0);
    rd_chk("srst_cnt", 4'd14, 32'd6);
    rd_chk("srst_ctrl", 4'd0, 32'hF);

    // 6: enables, retained stats, reset mid-pulse
    apb_wr(4'd0, 32'h5);
    check("en_5", {28'd0, TVS_EN}, 32'h5);
    rd_chk("ctrl_5", 4'd0, 32'h5);
    rd_chk("min0_kept", 4'd6, 32'h0800);
    apb_wr(4'd1, 32'h2);
    repeat (4) @(negedge PCLK);
    check("hclr_mid", {31'd0, TVS_TEMP_HIGH_CLEAR}, 32'd1);
    #2;
    PRESETN = 1'b0;
    #1;
    check("rst_mid_hclr", {31'd0, TVS_TEMP_HIGH_CLEAR}, 32'd0);
    check("rst_mid_en", {28'd0, TVS_EN}, 32'hF);
    @(negedge PCLK);
    PRESETN = 1'b1;
    rd_chk("post_rst_cnt", 4'd14, 32'd0);
    rd_chk("post_rst_min0", 4'd6, 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
